// File: rtl/spi_tuning_rx_if.sv
// SPI pins plus tuning-update outputs of the SPI tuning receiver.
// Clock and reset stay outside as plain ports.
interface spi_tuning_rx_if;
    logic        i_spi_sclk;
    logic        i_spi_cs_n;
    logic        i_spi_mosi;
    logic        o_spi_miso;
    logic        o_SPI_flag;
    logic [31:0] o_SPI_tuning_code;
    logic [7:0]  o_SPI_voice_index;
    logic        o_frame_error;
    logic [7:0]  o_err_count;

    modport master (
        output i_spi_sclk, i_spi_cs_n, i_spi_mosi,
        input  o_spi_miso, o_SPI_flag, o_SPI_tuning_code, o_SPI_voice_index,
               o_frame_error, o_err_count
    );

    modport slave (
        input  i_spi_sclk, i_spi_cs_n, i_spi_mosi,
        output o_spi_miso, o_SPI_flag, o_SPI_tuning_code, o_SPI_voice_index,
               o_frame_error, o_err_count
    );
endinterface

// File: rtl/spi_tuning_rx.sv
// SPI mode-0 slave that receives 40-bit {voice, delta-phase} frames and
// publishes validated tuning updates in the i_clk domain.
module spi_tuning_rx #(
    parameter int NUM_VOICES  = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    spi_tuning_rx_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RECV, COMMIT} state_e;

    localparam logic [8:0] NV_LIM = 9'(NUM_VOICES);

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, warm_q;
    logic                   sclk_prev_q, armed_q;
    logic                   sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [39:0] shift_q, shift_d;
    logic [7:0]  echo_q, echo_d;
    logic        partial_q, partial_d;
    logic        flag_q, flag_d, ferr_q, ferr_d;
    logic [31:0] code_q, code_d;
    logic [7:0]  vidx_q, vidx_d, errcnt_q, errcnt_d;
    logic        reject;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    // warm_q marks when the cs synchronizer holds a real pin sample rather
    // than its reset value; a frame begun before that is a leftover partial.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            warm_q      <= '0;
            sclk_prev_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q[0] <= bus.i_spi_sclk;
            cs_sync_q[0]   <= bus.i_spi_cs_n;
            mosi_sync_q[0] <= bus.i_spi_mosi;
            warm_q[0]      <= 1'b1;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sclk_sync_q[k] <= sclk_sync_q[k-1];
                cs_sync_q[k]   <= cs_sync_q[k-1];
                mosi_sync_q[k] <= mosi_sync_q[k-1];
                warm_q[k]      <= warm_q[k-1];
            end
            sclk_prev_q <= sclk_s;
            if (warm_q[SYNC_STAGES-1] && cs_s) armed_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!cs_s) state_d = RECV;
            RECV:    if (cs_s)  state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        echo_d    = echo_q;
        partial_d = partial_q;
        flag_d    = 1'b0;
        ferr_d    = 1'b0;
        code_d    = code_q;
        vidx_d    = vidx_q;
        errcnt_d  = errcnt_q;
        reject    = 1'b0;
        case (state_q)
            IDLE: if (!cs_s) begin
                cnt_d     = 6'd0;
                echo_d    = vidx_q;
                partial_d = ~armed_q;
            end
            RECV: begin
                if (sclk_rise) begin
                    shift_d = {shift_q[38:0], mosi_s};
                    if (cnt_q != 6'd41) cnt_d = cnt_q + 6'd1;
                end
                if (sclk_fall) echo_d = {echo_q[6:0], 1'b0};
            end
            COMMIT: begin
                if (partial_q)
                    reject = (cnt_q != 6'd0);
                else if (cnt_q == 6'd40 && {1'b0, shift_q[39:32]} < NV_LIM) begin
                    flag_d = 1'b1;
                    code_d = shift_q[31:0];
                    vidx_d = shift_q[39:32];
                end else
                    reject = 1'b1;
                if (reject) begin
                    ferr_d = 1'b1;
                    if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q     <= '0;
            shift_q   <= '0;
            echo_q    <= '0;
            partial_q <= 1'b0;
            flag_q    <= 1'b0;
            ferr_q    <= 1'b0;
            code_q    <= '0;
            vidx_q    <= '0;
            errcnt_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            echo_q    <= echo_d;
            partial_q <= partial_d;
            flag_q    <= flag_d;
            ferr_q    <= ferr_d;
            code_q    <= code_d;
            vidx_q    <= vidx_d;
            errcnt_q  <= errcnt_d;
        end
    end

    assign bus.o_spi_miso        = (state_q == RECV) & echo_q[7];
    assign bus.o_SPI_flag        = flag_q;
    assign bus.o_frame_error     = ferr_q;
    assign bus.o_SPI_tuning_code = code_q;
    assign bus.o_SPI_voice_index = vidx_q;
    assign bus.o_err_count       = errcnt_q;
endmodule

// File: tb/tb_spi_tuning_rx.sv
// Bench for spi_tuning_rx: frames are scored by a frame-level model that
// predicts each update/reject and the exact cycle of its pulse.
module tb_spi_tuning_rx;
    localparam int NV = 128;
    localparam int SS = 2;
    localparam int NONE = 0, ACC = 1, REJ = 2;

    logic i_clk = 1'b0;
    logic i_reset_n;
    always #5 i_clk = ~i_clk;

    spi_tuning_rx_if bus();
    spi_tuning_rx #(.NUM_VOICES(NV), .SYNC_STAGES(SS)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .bus(bus)
    );

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    bit chk_en = 1'b0;

    // model state
    logic [31:0] m_code = '0, pend_code = '0;
    logic [7:0]  m_idx = '0, m_err = '0, pend_idx = '0;
    int ev_cyc = -1, ev_kind = NONE;
    int nflags = 0, nferr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge i_clk) begin
        if (chk_en) begin
            if (cyc == ev_cyc) begin
                if (ev_kind == ACC) begin
                    m_code = pend_code;
                    m_idx  = pend_idx;
                end else if (ev_kind == REJ && m_err != 8'hFF)
                    m_err = m_err + 8'd1;
            end
            chk("flag", 64'(bus.o_SPI_flag), 64'(cyc == ev_cyc && ev_kind == ACC));
            chk("frame_error", 64'(bus.o_frame_error), 64'(cyc == ev_cyc && ev_kind == REJ));
            chk("tuning_code", 64'(bus.o_SPI_tuning_code), 64'(m_code));
            chk("voice_index", 64'(bus.o_SPI_voice_index), 64'(m_idx));
            chk("err_count", 64'(bus.o_err_count), 64'(m_err));
            if (bus.o_SPI_flag) nflags++;
            if (bus.o_frame_error) nferr++;
        end
    end

    task automatic cs_fall();
        @(negedge i_clk);
        bus.i_spi_cs_n = 1'b0;
        repeat (4) @(negedge i_clk);
    endtask

    // MISO is checked just before each rising sclk, where a mode-0 master samples it.
    task automatic send_bits(input int n, input logic [39:0] data, input bit chk_miso,
                             input logic [7:0] echo);
        for (int i = 0; i < n; i++) begin
            bus.i_spi_mosi = (i < 40) ? data[39-i] : 1'($urandom);
            bus.i_spi_sclk = 1'b0;
            repeat (4) @(negedge i_clk);
            if (chk_miso) chk("miso", 64'(bus.o_spi_miso), 64'((i < 8) ? echo[7-i] : 1'b0));
            bus.i_spi_sclk = 1'b1;
            repeat (4) @(negedge i_clk);
        end
        bus.i_spi_sclk = 1'b0;
        repeat (4) @(negedge i_clk);
    endtask

    // cs_n goes high now; the next posedge samples it, and the pulse must be
    // visible after SS+1 further edges (SS+2 edges counting the sampling one).
    task automatic cs_rise(input int kind, input logic [39:0] data);
        pend_code = data[31:0];
        pend_idx  = data[39:32];
        ev_kind   = kind;
        ev_cyc    = cyc + SS + 2;
        bus.i_spi_cs_n = 1'b1;
        repeat (SS + 8) @(negedge i_clk);
    endtask

    task automatic frame(input int n, input logic [39:0] data, input bit chk_miso,
                         input logic [7:0] echo);
        int kind;
        kind = (n == 40 && int'(data[39:32]) < NV) ? ACC : REJ;
        cs_fall();
        send_bits(n, data, chk_miso, echo);
        cs_rise(kind, data);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] d;
        int n, r;
        i_reset_n = 1'b0;
        bus.i_spi_cs_n = 1'b1;
        bus.i_spi_sclk = 1'b0;
        bus.i_spi_mosi = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst_flag", 64'(bus.o_SPI_flag), 64'd0);
        chk("rst_code", 64'(bus.o_SPI_tuning_code), 64'd0);
        chk("rst_err", 64'(bus.o_err_count), 64'd0);
        chk("rst_miso", 64'(bus.o_spi_miso), 64'd0);
        i_reset_n = 1'b1;
        chk_en = 1'b1;
        repeat (6) @(negedge i_clk);

        frame(40, 40'h05_1234ABCD, 1'b1, 8'h00);
        chk("lit_idx05", 64'(bus.o_SPI_voice_index), 64'h05);
        chk("lit_code", 64'(bus.o_SPI_tuning_code), 64'h1234ABCD);
        chk("lit_err0", 64'(bus.o_err_count), 64'd0);
        chk("lit_nflags1", 64'(nflags), 64'd1);

        frame(39, 40'h11_22223333, 1'b1, 8'h05);
        frame(41, 40'h12_44445555, 1'b0, 8'h00);
        chk("lit_err2", 64'(bus.o_err_count), 64'd2);
        chk("lit_hold_idx", 64'(bus.o_SPI_voice_index), 64'h05);
        chk("lit_hold_code", 64'(bus.o_SPI_tuning_code), 64'h1234ABCD);
        chk("lit_nferr2", 64'(nferr), 64'd2);

        frame(40, 40'h80_CAFEF00D, 1'b0, 8'h00);
        chk("lit_err3", 64'(bus.o_err_count), 64'd3);
        frame(40, 40'h7F_0BADBEEF, 1'b0, 8'h00);
        chk("lit_idx7f", 64'(bus.o_SPI_voice_index), 64'h7F);
        chk("lit_nflags2", 64'(nflags), 64'd2);

        frame(40, 40'h2A_00000001, 1'b1, 8'h7F);
        frame(40, 40'h33_87654321, 1'b1, 8'h2A);

        // reset in the middle of bit 20, released while cs_n is still low
        cs_fall();
        send_bits(20, 40'h44_55667788, 1'b0, 8'h00);
        chk_en = 1'b0;
        @(negedge i_clk);
        #2 i_reset_n = 1'b0;
        #1;
        chk("mid_rst_flag", 64'(bus.o_SPI_flag), 64'd0);
        chk("mid_rst_ferr", 64'(bus.o_frame_error), 64'd0);
        chk("mid_rst_code", 64'(bus.o_SPI_tuning_code), 64'd0);
        chk("mid_rst_idx", 64'(bus.o_SPI_voice_index), 64'd0);
        chk("mid_rst_err", 64'(bus.o_err_count), 64'd0);
        chk("mid_rst_miso", 64'(bus.o_spi_miso), 64'd0);
        m_code = '0; m_idx = '0; m_err = '0; ev_cyc = -1; ev_kind = NONE;
        repeat (3) @(negedge i_clk);
        i_reset_n = 1'b1;
        chk_en = 1'b1;
        send_bits(5, 40'hFF_FFFFFFFF, 1'b0, 8'h00);
        cs_rise(REJ, 40'h0);
        chk("lit_partial_err1", 64'(bus.o_err_count), 64'd1);
        frame(40, 40'h09_DEADBEEF, 1'b1, 8'h00);
        chk("lit_after_rst_idx", 64'(bus.o_SPI_voice_index), 64'h09);

        for (int f = 0; f < 25; f++) begin
            r = $urandom_range(0, 9);
            n = (r == 6) ? 39 : (r == 7) ? 41 : (r == 8) ? $urandom_range(0, 45) : 40;
            d[39:32] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(128, 255))
                                                   : 8'($urandom_range(0, 127));
            d[31:0] = $urandom;
            frame(n, d, 1'b1, m_idx);
        end

        repeat (256) frame(0, 40'h0, 1'b0, 8'h00);
        chk("lit_sat255", 64'(bus.o_err_count), 64'd255);
        frame(41, 40'h01_00000000, 1'b0, 8'h00);
        chk("lit_sat_hold", 64'(bus.o_err_count), 64'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
